// File: rtl/fft_pkg.sv
// Shared FFT-stage constants, twiddle word layout and the per-stage
// twiddle ROM address function.
package fft_pkg;

    localparam int LOG2N   = 7;
    localparam int ADDR_W  = LOG2N - 1;
    localparam int TW_W    = 14;
    localparam int STAGE_W = 3;
    localparam int NUM_BF  = 1 << ADDR_W;

    typedef struct packed {
        logic [TW_W-1:0] re;
        logic [TW_W-1:0] im;
    } tw_word_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fetch_state_t;

    // k(j) = (j & (2^s - 1)) << (LOG2N-1-s); the mask wraps to all-ones at s = ADDR_W.
    function automatic logic [ADDR_W-1:0] tw_index(input logic [ADDR_W-1:0] j,
                                                   input logic [STAGE_W-1:0] s);
        logic [ADDR_W:0] mask;
        mask = ((ADDR_W+1)'(1) << s) - (ADDR_W+1)'(1);
        return (j & mask[ADDR_W-1:0]) << (STAGE_W'(LOG2N-1) - s);
    endfunction

endpackage

// File: rtl/twiddle_fetch_if.sv
// Twiddle delivery bus towards the butterfly datapath (valid/ready).
interface twiddle_fetch_if;
    import fft_pkg::*;

    logic [TW_W-1:0]   tw_re;
    logic [TW_W-1:0]   tw_im;
    logic [ADDR_W-1:0] tw_idx;
    logic              tw_valid;
    logic              tw_ready;

    modport master (output tw_re, tw_im, tw_idx, tw_valid, input tw_ready);
    modport slave  (input tw_re, tw_im, tw_idx, tw_valid, output tw_ready);

endinterface

// File: rtl/tw_fifo.sv
// Synchronous show-ahead FIFO; head entry is always visible on dout.
module tw_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push is legal even when full.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_q] <= din;
                wr_q      <= next_ptr(wr_q);
            end
            if (do_pop) rd_q <= next_ptr(rd_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/twiddle_fetch.sv
// Twiddle ROM initiator for one radix-2 DIT stage: issues addresses under
// credit control, tags them through the ROM latency and buffers the results.
module twiddle_fetch
    import fft_pkg::*;
#(
    parameter int ROM_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [STAGE_W-1:0]   stage,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [2*TW_W-1:0]    rom_dout,
    twiddle_fetch_if.master      tw
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IF_W  = $clog2(ROM_LAT + 2);
    localparam int SUM_W = 8;
    localparam int ENT_W = ADDR_W + 2*TW_W;

    fetch_state_t         state_q, state_d;
    logic [ADDR_W-1:0]    j_q;
    logic [STAGE_W-1:0]   stage_q;
    logic [ROM_LAT:0]     tag_v;
    logic [ADDR_W-1:0]    tag_j [ROM_LAT+1];
    logic [IF_W-1:0]      inflight_q;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_empty, pop, issue, credit_ok, tag_exit;
    logic [SUM_W-1:0]     occ;
    logic [ENT_W-1:0]     fifo_dout;
    tw_word_t             head_word;

    assign pop      = tw.tw_valid && tw.tw_ready;
    assign tag_exit = tag_v[ROM_LAT];
    // Exiting tag is still counted in flight: it lands in the FIFO on this edge.
    assign occ       = SUM_W'(fifo_count) + SUM_W'(inflight_q);
    assign credit_ok = occ < (SUM_W'(FIFO_DEPTH) + SUM_W'(pop));

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: begin
                issue = credit_ok;
                if (credit_ok && j_q == ADDR_W'(NUM_BF - 1)) state_d = DRAIN;
            end
            DRAIN: if (inflight_q == '0 && fifo_empty) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy = (state_q == ISSUE) || (state_q == DRAIN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            j_q        <= '0;
            stage_q    <= '0;
            rom_addr   <= '0;
            inflight_q <= '0;
            tag_v      <= '0;
            for (int unsigned i = 0; i <= ROM_LAT; i++) tag_j[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                j_q     <= '0;
                stage_q <= (stage >= STAGE_W'(LOG2N)) ? STAGE_W'(LOG2N - 1) : stage;
            end else if (issue) begin
                j_q <= j_q + ADDR_W'(1);
            end
            if (issue) rom_addr <= tw_index(j_q, stage_q);

            tag_v[0] <= issue;
            tag_j[0] <= j_q;
            for (int unsigned i = 1; i <= ROM_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_j[i] <= tag_j[i-1];
            end

            case ({issue, tag_exit})
                2'b10:   inflight_q <= inflight_q + IF_W'(1);
                2'b01:   inflight_q <= inflight_q - IF_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    tw_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_exit),
        .din   ({tag_j[ROM_LAT], rom_dout}),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_word   = tw_word_t'(fifo_dout[2*TW_W-1:0]);
    assign tw.tw_re    = head_word.re;
    assign tw.tw_im    = head_word.im;
    assign tw.tw_idx   = fifo_dout[ENT_W-1:2*TW_W];
    assign tw.tw_valid = !fifo_empty;

endmodule

// File: tb/tb_twiddle_fetch.sv
// Scoreboard bench for twiddle_fetch with a behavioural 1-cycle twiddle ROM.
module tb_twiddle_fetch;

    typedef struct packed {
        logic [5:0]  idx;
        logic [13:0] re;
        logic [13:0] im;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [2:0]  stage = 0;
    logic        busy, done;
    logic [5:0]  rom_addr;
    logic [27:0] rom_dout;

    twiddle_fetch_if tw_bus ();

    twiddle_fetch #(.ROM_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stage    (stage),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .tw       (tw_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= {14'(rom_addr) + 14'd100, 14'(rom_addr) + 14'd200};

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   done_base = 0;
    int   frame_xfers = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: consume expected entries on every accepted transfer.
    always @(negedge clk) begin
        if (!rst && tw_bus.tw_valid && tw_bus.tw_ready) begin
            if (frame_xfers == 0) first_cyc = cyc;
            last_cyc = cyc;
            frame_xfers++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got idx %0d expected no transfer", tw_bus.tw_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tw_idx", 32'(tw_bus.tw_idx), 32'(e.idx));
                check("tw_re",  32'(tw_bus.tw_re),  32'(e.re));
                check("tw_im",  32'(tw_bus.tw_im),  32'(e.im));
            end
        end
        if (!rst && done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", 32'(busy), 32'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int s);
        int eff, k;
        exp_t e;
        eff = (s > 6) ? 6 : s;
        for (int j = 0; j < 64; j++) begin
            k = (j % (1 << eff)) * (64 >> eff);
            e.idx = 6'(j);
            e.re  = 14'(k + 100);
            e.im  = 14'(k + 200);
            exp_q.push_back(e);
        end
        frame_xfers = 0;
        done_base = done_cnt;
        stage = 3'(s);
        start = 1;
        step();
        start = 0;
    endtask

    task automatic wait_done(input bit toggle, input int budget);
        int n;
        n = 0;
        while (done_cnt == done_base && n < budget) begin
            if (toggle) tw_bus.tw_ready = ~tw_bus.tw_ready;
            step();
            n++;
        end
        if (n >= budget) check("done_timeout", 32'(n), 32'(0));
        tw_bus.tw_ready = 1;
        repeat (3) step();
        check("done_pulses", 32'(done_cnt - done_base), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("frame_xfers", 32'(frame_xfers), 32'd64);
        check("queue_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_idx(input logic [5:0] idx);
        int n;
        n = 0;
        while (!(tw_bus.tw_valid && tw_bus.tw_idx == idx) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check("wait_idx_timeout", 32'(idx), 32'hFFFF);
    endtask

    initial begin
        int lat;
        logic [5:0] held;
        tw_bus.tw_ready = 1;
        repeat (2) step();
        rst = 0;

        // Reset state
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_addr",  32'(rom_addr), 32'd0);
        check("rst_valid", 32'(tw_bus.tw_valid), 32'd0);
        check("rst_re",    32'(tw_bus.tw_re), 32'd0);
        check("rst_im",    32'(tw_bus.tw_im), 32'd0);
        check("rst_idx",   32'(tw_bus.tw_idx), 32'd0);

        // Stage 6, full rate: latency, throughput and done timing
        start_frame(6);
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        while (!tw_bus.tw_valid && lat < 20) begin
            step();
            lat++;
        end
        check("first_valid_latency", 32'(lat), 32'd3);
        wait_done(0, 400);
        check("burst_span", 32'(last_cyc - first_cyc), 32'd63);
        check("done_delay", 32'(done_cyc - last_cyc), 32'd2);

        // Stage 0: all addresses zero
        start_frame(0);
        wait_done(0, 400);

        // Stage 3 with a stray start mid-frame that must be ignored
        start_frame(3);
        repeat (10) step();
        stage = 0;
        start = 1;
        step();
        start = 0;
        check("busy_stray_start", 32'(busy), 32'd1);
        wait_done(0, 400);

        // Backpressure: stall 10 cycles while j=20 is presented
        start_frame(6);
        wait_idx(6'd20);
        tw_bus.tw_ready = 0;
        repeat (3) step();
        held = rom_addr;
        repeat (7) step();
        check("stall_addr_hold", 32'(rom_addr), 32'(held));
        check("stall_addr", 32'(rom_addr), 32'd23);
        check("stall_head_idx", 32'(tw_bus.tw_idx), 32'd20);
        tw_bus.tw_ready = 1;
        wait_done(0, 400);

        // Ready toggling every cycle
        start_frame(6);
        wait_done(1, 600);

        // Mid-frame reset at j=30
        start_frame(6);
        wait_idx(6'd30);
        rst = 1;
        exp_q.delete();
        step();
        rst = 0;
        check("mrst_valid", 32'(tw_bus.tw_valid), 32'd0);
        check("mrst_busy",  32'(busy), 32'd0);
        check("mrst_addr",  32'(rom_addr), 32'd0);
        check("mrst_done",  32'(done), 32'd0);
        repeat (5) step();
        check("mrst_no_done", 32'(done_cnt - done_base), 32'd0);
        start_frame(6);
        wait_done(0, 400);

        // Stage 7 clamps to stage 6
        start_frame(7);
        wait_done(0, 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/twiddle_fetch.md
Name: twiddle_fetch

Overview:
- Initiator side of the stage twiddle block ROM (6-bit address in, 28-bit word out, registered read).
- For one radix-2 DIT FFT stage, generates twiddle addresses for all N/2 butterflies and absorbs the ROM read latency.
- Delivers each twiddle, tagged with its butterfly index, to the butterfly datapath over a valid/ready interface with full backpressure.
- Sits between the stage controller (start/done) and the radix-2 butterfly.

Parameters:
- LOG2N, 7, log2 of FFT size; N/2 = 64 butterflies and 64 ROM entries.
- ADDR_W, 6, ROM address width (= LOG2N-1).
- TW_W, 14, width of each twiddle component; ROM word is 2*TW_W = 28.
- ROM_LAT, 1, cycles from address sampled by the ROM to valid douta.
- FIFO_DEPTH, 4, output buffer depth; must be >= ROM_LAT+2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to fetch a stage; honoured only in IDLE
- stage  in  3  stage number 0..LOG2N-1, sampled with start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse once the last twiddle is consumed
- rom_addr  out  ADDR_W  registered address to twiddle ROM addra
- rom_dout  in  2*TW_W  ROM douta; [27:14] real, [13:0] imag
- tw_re  out  TW_W  twiddle real part
- tw_im  out  TW_W  twiddle imaginary part
- tw_idx  out  ADDR_W  butterfly index j of the presented twiddle
- tw_valid  out  1  twiddle presented
- tw_ready  in  1  consumer accepts; transfer when tw_valid & tw_ready

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; busy=0, done=0, rom_addr=0, tw_valid=0, tw_re/tw_im/tw_idx=0.
  - FIFO flushed, in-flight tags cleared, j=0.
  - Applies mid-frame too; all outstanding data is discarded.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE on start. Latch stage; a value >= LOG2N clamps to LOG2N-1. j=0.
  - ISSUE: issue j when credit allows, then j++. The edge that issues j=N/2-1 moves to DRAIN.
  - DRAIN -> DONE when in-flight=0 and FIFO empty.
  - DONE: done=1 for exactly one cycle, then IDLE. busy=0 from the DONE cycle onward.
- start outside IDLE is ignored; the latched stage is unchanged.
- Address: k(j) = (j & (2^s - 1)) << (LOG2N-1-s), where s is the latched stage.
  - s=0: all k=0. s=LOG2N-1: k=j.
- Issue at edge e: rom_addr <= k(j); tag {valid, j} enters a ROM_LAT+1 stage shift register.
  - When a tag exits (edge e+ROM_LAT+1), rom_dout and j are written to the FIFO.
  - rom_addr holds its last value when not issuing.
- Credit: issue only if FIFO occupancy + in-flight tags + (pop ? -1 : 0) < FIFO_DEPTH.
  - No data is ever lost or duplicated; the ROM has no enable, so data is captured only via tags.
- FIFO: show-ahead. tw_valid = !empty; outputs driven from the head entry. Simultaneous push and pop is legal at any occupancy, including full.
- Timing with tw_ready=1 and ROM_LAT=1:
  - start sampled at edge 0; first issue at edge 1; first tw_valid after edge 3.
  - Then one twiddle per cycle; 64 transfers in 64 consecutive cycles.
  - done pulses 2 cycles after the last transfer.

Decomposition:
- Package fft_pkg: LOG2N, ADDR_W, TW_W, the twiddle word layout (re high, im low), and a function tw_index(j, s).
- Sub-module tw_fifo: small synchronous show-ahead FIFO, parameterised width/depth, count output, sync active-high reset.
- FSM, credit counter and tag pipeline stay in twiddle_fetch.
- Bench ROM model: latency ROM_LAT; word at address a = {a+100, a+200} (14 bits each), so data correctness is checkable.

Test Plan:
1. Reset, stage=6, start, tw_ready=1 -> 64 transfers tw_idx 0..63, tw_re=j+100, tw_im=j+200; first tw_valid 3 cycles after start edge; single done pulse; busy falls.
2. stage=0 -> 64 transfers, every rom_addr=0, all tw_re=100, tw_im=200, tw_idx still 0..63.
3. stage=3 -> k=(j&7)<<3: j=9 gives addr 8 (tw_re=108); j=63 gives addr 56 (tw_re=156).
4. stage=6, drop tw_ready for 10 cycles at j=20 -> rom_addr stops advancing with <=4 outstanding; after release the sequence continues 20,21,... with no gap or duplicate. Also toggle tw_ready every cycle: all 64 delivered in order.
5. rst for 1 cycle while j=30 -> next cycle tw_valid=0, busy=0, rom_addr=0, done stays 0; a new start restarts at tw_idx=0 with no stale data.
6. start pulsed while busy -> ignored, frame unaffected. stage=7 with start -> behaves as stage 6 (addr=j).
